pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 10, program-counter and branch-target width.
REQ-002 SHALL have parameter PTR_W, default 5, branch-target lookup pointer width.
REQ-003 SHALL have parameter START_PC, default 0, PC value loaded on Start.
REQ-004 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port Start  input  1  begin-program request.
REQ-007 SHALL have port Halt  input  1  decoded halt of the current instruction.
REQ-008 SHALL have port Stall  input  1  freeze sequencing this cycle.
REQ-009 SHALL have port BranchEn  input  1  current instruction takes a branch.
REQ-010 SHALL have port BranchPtr  input  PTR_W  target-table pointer from the instruction.
REQ-011 SHALL have port LutTarget  input  PC_W  combinational target-table data for LutAddr.
REQ-012 SHALL have port LutAddr  output  PTR_W  registered target-table pointer.
REQ-013 SHALL have port PC  output  PC_W  current fetch address.
REQ-014 SHALL have port Fetch  output  1  PC is a valid instruction this cycle.
REQ-015 SHALL have port Busy  output  1  program executing (RUN or REDIRECT).
REQ-016 SHALL have port Done  output  1  program halted; level, held until next accepted Start.
REQ-017 SHALL have port InstrCount  output  16  retired-instruction count of the current run.

Function
REQ-018 SHALL implement states IDLE, RUN, REDIRECT, DONE; Busy=1 exactly in RUN/REDIRECT; Done=1 exactly in DONE.
REQ-019 SHALL accept Start only in IDLE or DONE: next cycle PC=START_PC, InstrCount=0, state RUN; Start in RUN/REDIRECT ignored.
REQ-020 SHALL drive Fetch=1 only in RUN with Stall=0.
REQ-021 SHALL, in RUN with Stall=1, hold PC, LutAddr, InstrCount and state.
REQ-022 SHALL, in RUN with Stall=0, retire the instruction at PC: InstrCount+1, saturating at 16'hFFFF.
REQ-023 SHALL apply priority Halt > BranchEn > sequential for a retiring instruction.
REQ-024 SHALL, on retiring Halt, hold PC and enter DONE.
REQ-025 SHALL, on retiring BranchEn (Halt=0), register LutAddr<=BranchPtr, hold PC, enter REDIRECT.
REQ-026 SHALL, on retiring neither, set PC<=PC+1 modulo 2^PC_W (1023 wraps to 0 at default), stay RUN.
REQ-027 SHALL, in REDIRECT with Stall=0, load PC<=LutTarget and return to RUN; branch costs exactly one bubble cycle (Fetch=0).
REQ-028 SHALL, in REDIRECT with Stall=1, hold all state; Halt/BranchEn/Start ignored in REDIRECT.
REQ-029 SHALL ignore Halt, BranchEn, Stall in IDLE and DONE; PC and InstrCount hold final values in DONE.
REQ-030 SHALL keep LutAddr unchanged except on a retiring branch.

Reset
REQ-031 SHALL, on Reset=0 at any time including mid-run, immediately force state IDLE, PC=START_PC, LutAddr=0, InstrCount=0, Fetch=0, Busy=0, Done=0.
REQ-032 SHALL resume only via Start after Reset deasserts; Start sampled in the first cycle after deassertion is accepted.

Verification
REQ-033 Start pulse, no branch/halt, 5 cycles -> PC 0,1,2,3,4, Fetch=1 each, InstrCount=5, Busy=1.
REQ-034 At PC=3 BranchEn=1, BranchPtr=1, LutTarget=10'h020 -> LutAddr=1, next cycle Fetch=0 PC=3, following cycle PC=10'h020 Fetch=1; InstrCount counts branch once.
REQ-035 Halt at PC=7 with BranchEn=1 same cycle -> DONE, PC=7, Done=1, LutAddr unchanged; second Start -> PC=0, InstrCount=0, Done=0.
REQ-036 Stall=1 for 3 cycles in RUN at PC=2, then 3 cycles during REDIRECT -> PC, InstrCount frozen, Fetch=0, no extra bubble beyond one.
REQ-037 Run from PC=10'h3FE sequentially -> 3FE, 3FF, 000; Start asserted during RUN -> no effect.
REQ-038 Reset=0 asynchronously in REDIRECT -> same-cycle IDLE, PC=0, LutAddr=0, all outputs 0; Start after release restarts at 0.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Bus bundle for the program-counter sequencer.
// Handshake: Start is a single-cycle request, accepted only when the
// sequencer is idle or done. Fetch is the valid for PC. It is high only
// while running and not stalled, and there is no ready on the fetch side.
interface pc_sequencer_if #(
  parameter int PC_W  = 10,
  parameter int PTR_W = 5
);
  logic             Start;
  logic             Halt;
  logic             Stall;
  logic             BranchEn;
  logic [PTR_W-1:0] BranchPtr;
  logic [PC_W-1:0]  LutTarget;
  logic [PTR_W-1:0] LutAddr;
  logic [PC_W-1:0]  PC;
  logic             Fetch;
  logic             Busy;
  logic             Done;
  logic [15:0]      InstrCount;

  // Driver side: issues control and returns target-table data.
  modport master (
    output Start, Halt, Stall, BranchEn, BranchPtr, LutTarget,
    input  LutAddr, PC, Fetch, Busy, Done, InstrCount
  );

  // Sequencer side.
  modport slave (
    input  Start, Halt, Stall, BranchEn, BranchPtr, LutTarget,
    output LutAddr, PC, Fetch, Busy, Done, InstrCount
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer. It steps PC sequentially, takes table-driven
// branches with a single bubble cycle, halts, and counts retired
// instructions.
module pc_sequencer #(
  parameter int PC_W     = 10,
  parameter int PTR_W    = 5,
  parameter int START_PC = 0
) (
  input  logic                Clk,
  input  logic                Reset,
  pc_sequencer_if.slave       bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_REDIRECT = 2'd2,
    S_DONE     = 2'd3
  } state_e;

  localparam logic [PC_W-1:0] START_PC_V = PC_W'(START_PC);

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PTR_W-1:0] lut_addr_q, lut_addr_d;
  logic [15:0]      icount_q, icount_d;

  // State register. Reset forces IDLE at once, so the outputs drop immediately.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      pc_q       <= START_PC_V;
      lut_addr_q <= '0;
      icount_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      lut_addr_q <= lut_addr_d;
      icount_q   <= icount_d;
    end
  end

  // Next-state logic. The priority for a retiring instruction is Halt, then BranchEn, then sequential.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    lut_addr_d = lut_addr_q;
    icount_d   = icount_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.Start) begin
          state_d  = S_RUN;
          pc_d     = START_PC_V;
          icount_d = '0;
        end
      end
      S_RUN: begin
        if (!bus.Stall) begin
          if (icount_q != 16'hFFFF) icount_d = icount_q + 16'd1;
          if (bus.Halt) begin
            state_d = S_DONE;
          end else if (bus.BranchEn) begin
            lut_addr_d = bus.BranchPtr;
            state_d    = S_REDIRECT;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end
      S_REDIRECT: begin
        if (!bus.Stall) begin
          pc_d    = bus.LutTarget;
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    bus.PC         = pc_q;
    bus.LutAddr    = lut_addr_q;
    bus.InstrCount = icount_q;
    bus.Fetch      = (state_q == S_RUN) && !bus.Stall;
    bus.Busy       = (state_q == S_RUN) || (state_q == S_REDIRECT);
    bus.Done       = (state_q == S_DONE);
    dbg_state      = state_q;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer. It uses a behavioural reference model, an
// expected-state queue, directed scenarios and a random phase.
module tb_pc_sequencer;
  localparam int PC_W  = 10;
  localparam int PTR_W = 5;
  localparam logic [1:0] M_IDLE = 2'd0, M_RUN = 2'd1, M_REDIR = 2'd2, M_DONE = 2'd3;

  logic Clk;
  logic Reset;
  logic [1:0] dbg_state;

  pc_sequencer_if #(.PC_W(PC_W), .PTR_W(PTR_W)) bus ();

  pc_sequencer #(.PC_W(PC_W), .PTR_W(PTR_W), .START_PC(0)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Combinational target table.
  logic [PC_W-1:0] lut_mem [0:(1<<PTR_W)-1];
  always_comb bus.LutTarget = lut_mem[bus.LutAddr];

  // scoreboard
  logic [32:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [1:0]       m_state;
  logic [PC_W-1:0]  m_pc;
  logic [PTR_W-1:0] m_lut;
  logic [15:0]      m_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_pc    = '0;
    m_lut   = '0;
    m_cnt   = '0;
  endtask

  // Drive one cycle, check the combinational outputs, predict the next state and compare after the edge.
  task automatic step(input logic st, input logic hl, input logic sl,
                      input logic br, input logic [PTR_W-1:0] ptr);
    logic [1:0]       ns;
    logic [PC_W-1:0]  npc;
    logic [PTR_W-1:0] nl;
    logic [15:0]      nc;
    logic [32:0]      got;
    @(negedge Clk);
    bus.Start = st; bus.Halt = hl; bus.Stall = sl; bus.BranchEn = br; bus.BranchPtr = ptr;
    #1;
    check("fetch", bus.Fetch, (m_state == M_RUN) && !sl);
    check("busy",  bus.Busy,  (m_state == M_RUN) || (m_state == M_REDIR));
    check("done",  bus.Done,  m_state == M_DONE);
    ns = m_state; npc = m_pc; nl = m_lut; nc = m_cnt;
    case (m_state)
      M_IDLE, M_DONE: if (st) begin ns = M_RUN; npc = '0; nc = '0; end
      M_RUN: if (!sl) begin
        if (m_cnt != 16'hFFFF) nc = m_cnt + 16'd1;
        if (hl) ns = M_DONE;
        else if (br) begin nl = ptr; ns = M_REDIR; end
        else npc = m_pc + 1'b1;
      end
      default: if (!sl) begin npc = lut_mem[m_lut]; ns = M_RUN; end
    endcase
    m_state = ns; m_pc = npc; m_lut = nl; m_cnt = nc;
    exp_q.push_back({m_state, m_pc, m_lut, m_cnt});
    @(posedge Clk);
    #1;
    got = {dbg_state, bus.PC, bus.LutAddr, bus.InstrCount};
    if (exp_q.size() == 0) check("queue_empty", 1, 0);
    else check("post_edge", got, exp_q.pop_front());
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    for (int i = 0; i < (1 << PTR_W); i++) lut_mem[i] = PC_W'($urandom_range(0, 1023));
    lut_mem[1] = 10'h020;
    lut_mem[2] = 10'h3FE;
    lut_mem[4] = 10'h005;
    bus.Start = 0; bus.Halt = 0; bus.Stall = 0; bus.BranchEn = 0; bus.BranchPtr = '0;
    Reset = 1'b0;
    model_reset();
    #12;
    check("rst_pc", bus.PC, 0);
    check("rst_busy", bus.Busy, 0);
    check("rst_done", bus.Done, 0);
    check("rst_cnt", bus.InstrCount, 0);
    @(negedge Clk); Reset = 1'b1;

    // Sequential run of five instructions, then halt.
    step(1, 0, 0, 0, '0);
    for (int i = 0; i < 5; i++) begin
      check("seq_pc", bus.PC, i);
      idle_step();
    end
    check("seq_cnt", bus.InstrCount, 5);
    check("seq_busy", bus.Busy, 1);
    step(0, 1, 0, 0, '0);
    check("halt_done", bus.Done, 1);

    // Branch at PC=3 through table entry 1.
    step(1, 0, 0, 0, '0);
    repeat (3) idle_step();
    check("br_pc3", bus.PC, 3);
    step(0, 0, 0, 1, 5'd1);
    check("br_lutaddr", bus.LutAddr, 1);
    check("br_bubble_pc", bus.PC, 3);
    idle_step();
    check("br_target", bus.PC, 10'h020);
    check("br_cnt", bus.InstrCount, 4);
    step(0, 1, 0, 0, '0);

    // Stalls in RUN and in REDIRECT.
    step(1, 0, 0, 0, '0);
    repeat (2) idle_step();
    repeat (3) step(0, 1, 1, 1, 5'd9);
    check("stall_pc", bus.PC, 2);
    check("stall_cnt", bus.InstrCount, 2);
    step(0, 0, 0, 1, 5'd4);
    repeat (3) step(1, 1, 1, 1, 5'd7);
    check("stall_redir_pc", bus.PC, 2);
    idle_step();
    check("stall_target", bus.PC, 5);
    repeat (2) idle_step();
    check("pc7", bus.PC, 7);
    step(0, 1, 0, 1, 5'd3);
    check("halt_pc", bus.PC, 7);
    check("halt_lut", bus.LutAddr, 4);
    step(0, 1, 1, 1, 5'd8);
    step(1, 0, 0, 0, '0);
    check("restart_pc", bus.PC, 0);
    check("restart_cnt", bus.InstrCount, 0);
    check("restart_done", bus.Done, 0);

    // Wrap from 3FE to 0, with Start ignored while running.
    step(0, 0, 0, 1, 5'd2);
    idle_step();
    check("wrap_3fe", bus.PC, 10'h3FE);
    step(1, 0, 0, 0, '0);
    check("wrap_3ff", bus.PC, 10'h3FF);
    step(1, 0, 0, 0, '0);
    check("wrap_000", bus.PC, 0);

    // Asynchronous reset in REDIRECT.
    step(0, 0, 0, 1, 5'd3);
    @(negedge Clk); #2;
    Reset = 1'b0;
    #1;
    model_reset();
    check("areset_state", dbg_state, M_IDLE);
    check("areset_pc", bus.PC, 0);
    check("areset_lut", bus.LutAddr, 0);
    check("areset_cnt", bus.InstrCount, 0);
    check("areset_outs", {bus.Fetch, bus.Busy, bus.Done}, 0);
    @(negedge Clk); Reset = 1'b1;
    step(1, 0, 0, 0, '0);
    check("post_reset_pc", bus.PC, 0);
    check("post_reset_busy", bus.Busy, 1);

    // Random phase.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
           PTR_W'($urandom_range(0, 31)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
